// File: rtl/sl_pkg.sv
// Shared SL serial-line definitions: arbiter states and legal word-length bounds.
package sl_pkg;

    typedef enum logic [1:0] {StIdle, StIssue, StWaitDone, StGap} sl_state_e;

    localparam int unsigned SL_LEN_MIN = 8;
    localparam int unsigned SL_LEN_MAX = 32;

    function automatic logic sl_len_ok(input int unsigned len);
        return (len >= SL_LEN_MIN) && (len <= SL_LEN_MAX);
    endfunction

endpackage

// File: rtl/sl_rr_pick.sv
// Combinational winner select: rotating search from ptr_i in round-robin mode,
// lowest index first in fixed-priority mode.
module sl_rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PW    = 2
) (
    input  logic [N_REQ-1:0] elig_i,
    input  logic [PW-1:0]    ptr_i,
    input  logic             rr_en_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [PW-1:0]    idx_o,
    output logic             any_o
);

    always_comb begin : p_pick
        int unsigned c;
        logic        found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        c     = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            c = rr_en_i ? (32'(ptr_i) + k) % N_REQ : k;
            if (!found && elig_i[c[PW-1:0]]) begin
                found              = 1'b1;
                gnt_o[c[PW-1:0]]   = 1'b1;
                idx_o              = c[PW-1:0];
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/sl_tx_arbiter.sv
// Shares one SL transmit engine between N_REQ word sources; one word in flight,
// watchdog-supervised completion, programmable idle gap between words.
module sl_tx_arbiter
    import sl_pkg::*;
#(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DW     = 32,
    parameter int unsigned LW     = 6,
    parameter int unsigned GAP_W  = 8,
    parameter int unsigned TO_CYC = 2048
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_rr_en,
    input  logic [N_REQ-1:0]    cfg_req_mask,
    input  logic [GAP_W-1:0]    cfg_gap,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DW-1:0] req_data,
    input  logic [N_REQ*LW-1:0] req_len,
    input  logic [N_REQ-1:0]    req_parity,
    output logic [N_REQ-1:0]    req_ready,
    output logic [N_REQ-1:0]    req_done,
    output logic [N_REQ-1:0]    req_err,
    output logic                tx_start,
    output logic [DW-1:0]       tx_data,
    output logic [LW-1:0]       tx_len,
    output logic                tx_parity_en,
    input  logic                tx_done,
    input  logic                tx_err,
    output logic                busy,
    output logic [N_REQ-1:0]    cur_grant,
    output logic [15:0]         word_cnt
);

    localparam int unsigned PW  = $clog2(N_REQ);
    localparam int unsigned WDW = $clog2(TO_CYC + 1);

    sl_state_e        state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [N_REQ-1:0] err_q, err_d;
    logic [DW-1:0]    data_q, data_d;
    logic [LW-1:0]    len_q, len_d;
    logic             par_q, par_d;
    logic [WDW-1:0]   wdog_q, wdog_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [15:0]      cnt_q, cnt_d;

    logic [N_REQ-1:0] elig, pick_gnt;
    logic [PW-1:0]    pick_idx;
    logic             pick_any;
    logic [DW-1:0]    sel_data;
    logic [LW-1:0]    sel_len;
    logic             sel_par;

    assign elig = req_valid & cfg_req_mask;

    sl_rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .elig_i  (elig),
        .ptr_i   (ptr_q),
        .rr_en_i (cfg_rr_en),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    always_comb begin
        sel_data = '0;
        sel_len  = '0;
        sel_par  = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick_gnt[i]) begin
                sel_data = req_data[i*DW +: DW];
                sel_len  = req_len[i*LW +: LW];
                sel_par  = req_parity[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        done_d    = '0;
        err_d     = '0;
        data_d    = data_q;
        len_d     = len_q;
        par_d     = par_q;
        wdog_d    = wdog_q;
        gap_d     = gap_q;
        cnt_d     = cnt_q;
        req_ready = '0;
        tx_start  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Gate with rst_n so no accept is signalled while flops are held in reset.
                if (pick_any && rst_n) begin
                    req_ready = pick_gnt;
                    grant_d   = pick_gnt;
                    data_d    = sel_data;
                    len_d     = sel_len;
                    par_d     = sel_par;
                    ptr_d     = (32'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + 1'b1;
                    if (sl_len_ok(32'(sel_len))) begin
                        state_d = StIssue;
                    end else begin
                        err_d   = pick_gnt;
                        gap_d   = cfg_gap;
                        state_d = StGap;
                    end
                end
            end
            StIssue: begin
                tx_start = 1'b1;
                wdog_d   = '0;
                state_d  = StWaitDone;
            end
            StWaitDone: begin
                wdog_d = wdog_q + 1'b1;
                if (tx_err || (!tx_done && wdog_q == WDW'(TO_CYC - 1))) begin
                    err_d   = grant_q;
                    gap_d   = cfg_gap;
                    state_d = StGap;
                end else if (tx_done) begin
                    done_d  = grant_q;
                    cnt_d   = cnt_q + 16'd1;
                    gap_d   = cfg_gap;
                    state_d = StGap;
                end
            end
            StGap: begin
                if (gap_q == '0) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            data_q  <= '0;
            len_q   <= '0;
            par_q   <= 1'b0;
            wdog_q  <= '0;
            gap_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            data_q  <= data_d;
            len_q   <= len_d;
            par_q   <= par_d;
            wdog_q  <= wdog_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_done     = done_q;
    assign req_err      = err_q;
    assign tx_data      = data_q;
    assign tx_len       = len_q;
    assign tx_parity_en = par_q;
    assign busy         = (state_q != StIdle);
    assign cur_grant    = grant_q;
    assign word_cnt     = cnt_q;

endmodule

// File: tb/tb_sl_tx_arbiter.sv
// Randomized scoreboard bench for sl_tx_arbiter: a transaction-level model predicts grant order,
// captured words, outcomes and timing; a monitor compares every DUT transaction.
module tb_sl_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 40;

    typedef struct {
        logic [31:0] data;
        logic [5:0]  len;
        logic        par;
    } word_t;

    typedef struct {
        int  kind;  // 0 done, 1 err, 2 done+err, 3 silent
        int  dly;
        bit  echo;
        bit  echo_err;
    } resp_t;

    typedef struct {
        int          idx;
        word_t       w;
        bit          legal;
        logic [3:0]  done_vec;
        logic [3:0]  err_vec;
        logic [15:0] cnt;
        int          lat;
        int          gap;
        bit          b2b;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         cfg_rr_en;
    logic [3:0]   cfg_req_mask;
    logic [7:0]   cfg_gap;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [23:0]  req_len;
    logic [3:0]   req_parity;
    logic [3:0]   req_ready;
    logic [3:0]   req_done;
    logic [3:0]   req_err;
    logic         tx_start;
    logic [31:0]  tx_data;
    logic [5:0]   tx_len;
    logic         tx_parity_en;
    logic         tx_done;
    logic         tx_err;
    logic         busy;
    logic [3:0]   cur_grant;
    logic [15:0]  word_cnt;

    sl_tx_arbiter #(
        .N_REQ  (N),
        .DW     (32),
        .LW     (6),
        .GAP_W  (8),
        .TO_CYC (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_rr_en    (cfg_rr_en),
        .cfg_req_mask (cfg_req_mask),
        .cfg_gap      (cfg_gap),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_len      (req_len),
        .req_parity   (req_parity),
        .req_ready    (req_ready),
        .req_done     (req_done),
        .req_err      (req_err),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_len       (tx_len),
        .tx_parity_en (tx_parity_en),
        .tx_done      (tx_done),
        .tx_err       (tx_err),
        .busy         (busy),
        .cur_grant    (cur_grant),
        .word_cnt     (word_cnt)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last_res = 0;
    bit          mon_en = 0;
    bit          mon_busy = 0;
    int          model_ptr = 0;
    logic [15:0] model_cnt = '0;

    word_t stage[N][$];
    word_t wq[N][$];
    exp_t  exp_q[$];
    resp_t eng_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: still running at %0t, required finish earlier", $time);
        $fatal(1, "global time limit");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got 0x%0h, required 0x%0h", name, cyc, act, req);
        end
    endtask

    function automatic logic [3:0] oh(input int i);
        return 4'b0001 << i;
    endfunction

    function automatic int pick(input bit rr, input bit [3:0] el, input int p);
        for (int k = 0; k < N; k++) begin
            int c;
            c = rr ? (p + k) % N : k;
            if (el[c]) return c;
        end
        return -1;
    endfunction

    // Requesters: present queue head, advance one word per accept.
    initial begin
        logic [3:0] acc;
        req_valid  = '0;
        req_data   = '0;
        req_len    = '0;
        req_parity = '0;
        forever begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i] && wq[i].size() > 0) void'(wq[i].pop_front());
                if (wq[i].size() > 0) begin
                    req_valid[i]        = 1'b1;
                    req_data[i*32 +: 32] = wq[i][0].data;
                    req_len[i*6 +: 6]    = wq[i][0].len;
                    req_parity[i]        = wq[i][0].par;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    // Engine: answers each tx_start with the next scripted response.
    initial begin
        resp_t r;
        tx_done = 1'b0;
        tx_err  = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                if (eng_q.size() > 0) r = eng_q.pop_front();
                else r = '{kind: 3, dly: 1, echo: 1'b0, echo_err: 1'b0};
                if (r.kind != 3) begin
                    repeat (r.dly) @(posedge clk);
                    #1;
                    tx_done = (r.kind == 0) || (r.kind == 2);
                    tx_err  = (r.kind == 1) || (r.kind == 2);
                    @(posedge clk);
                    #1;
                    tx_done = 1'b0;
                    tx_err  = 1'b0;
                    if (r.echo) begin
                        @(posedge clk);
                        #1;
                        tx_done = 1'b1;
                        tx_err  = r.echo_err;
                        @(posedge clk);
                        #1;
                        tx_done = 1'b0;
                        tx_err  = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: one scoreboard entry per accepted word.
    initial begin
        exp_t e;
        int   t0;
        bit   got;
        forever begin
            @(negedge clk);
            if (!mon_en) continue;
            if (req_ready != '0) begin
                mon_busy = 1'b1;
                if (exp_q.size() == 0) begin
                    chk("unexpected_ready", 64'(req_ready), 64'(0));
                    mon_busy = 1'b0;
                    continue;
                end
                e = exp_q.pop_front();
                chk("grant", 64'(req_ready), 64'(oh(e.idx)));
                if (e.b2b) chk("gap_spacing", 64'(cyc - last_res), 64'(e.gap + 1));
                t0 = cyc;
                @(negedge clk);
                if (e.legal) begin
                    chk("tx_start", 64'(tx_start), 64'(1));
                    chk("tx_data", 64'(tx_data), 64'(e.w.data));
                    chk("tx_len", 64'(tx_len), 64'(e.w.len));
                    chk("tx_parity_en", 64'(tx_parity_en), 64'(e.w.par));
                    chk("cur_grant", 64'(cur_grant), 64'(oh(e.idx)));
                    t0  = cyc;
                    got = 1'b0;
                    for (int k = 0; k < TO + 20 && !got; k++) begin
                        @(negedge clk);
                        got = (req_done != '0) || (req_err != '0);
                    end
                    chk("result_seen", 64'(got), 64'(1));
                end else begin
                    chk("no_tx_start", 64'(tx_start), 64'(0));
                end
                chk("req_done", 64'(req_done), 64'(e.done_vec));
                chk("req_err", 64'(req_err), 64'(e.err_vec));
                chk("word_cnt", 64'(word_cnt), 64'(e.cnt));
                chk("result_latency", 64'(cyc - t0), 64'(e.lat));
                last_res = cyc;
                mon_busy = 1'b0;
            end else if (req_done != '0 || req_err != '0 || tx_start) begin
                chk("spurious_output", {55'd0, tx_start, req_done, req_err}, 64'(0));
            end
        end
    end

    task automatic push_word(input int i, input logic [31:0] d, input logic [5:0] l, input logic p);
        word_t w;
        w.data = d;
        w.len  = l;
        w.par  = p;
        stage[i].push_back(w);
    endtask

    task automatic gen_words(input int i, input int n, input int bad_pct);
        logic [5:0] l;
        for (int k = 0; k < n; k++) begin
            if (int'($urandom_range(0, 99)) < bad_pct) begin
                case ($urandom_range(0, 3))
                    0:       l = 6'd0;
                    1:       l = 6'd7;
                    2:       l = 6'd33;
                    default: l = 6'd63;
                endcase
            end else begin
                l = 6'($urandom_range(8, 32));
            end
            push_word(i, $urandom, l, 1'($urandom_range(0, 1)));
        end
    endtask

    // Reference model: every staged word stays valid until granted.
    task automatic run_episode(input bit rr, input logic [3:0] mask, input int gap,
                               input int force_kind, input bit toggle);
        int    pos[N];
        int    g;
        bit    first;
        bit [3:0] el;
        exp_t  e;
        resp_t r;
        int    k;
        cfg_rr_en    = rr;
        cfg_req_mask = mask;
        cfg_gap      = 8'(gap);
        first        = 1'b1;
        for (int i = 0; i < N; i++) pos[i] = 0;
        forever begin
            for (int i = 0; i < N; i++) el[i] = (pos[i] < stage[i].size()) && mask[i];
            g = pick(rr, el, model_ptr);
            if (g < 0) break;
            e.idx      = g;
            e.w        = stage[g][pos[g]];
            pos[g]++;
            model_ptr  = (g + 1) % N;
            e.legal    = (e.w.len >= 8) && (e.w.len <= 32);
            e.done_vec = '0;
            e.err_vec  = '0;
            if (e.legal) begin
                if (force_kind >= 0) begin
                    r.kind = force_kind;
                end else begin
                    k = int'($urandom_range(0, 99));
                    r.kind = (k < 70) ? 0 : (k < 82) ? 1 : (k < 95) ? 2 : 3;
                end
                r.dly      = int'($urandom_range(1, 5));
                r.echo     = ($urandom_range(0, 3) == 0);
                r.echo_err = 1'($urandom_range(0, 1));
                eng_q.push_back(r);
                if (r.kind == 0) begin
                    e.done_vec = oh(g);
                    model_cnt  = model_cnt + 16'd1;
                end else begin
                    e.err_vec = oh(g);
                end
                e.lat = (r.kind == 3) ? TO + 1 : r.dly + 1;
            end else begin
                e.err_vec = oh(g);
                e.lat     = 1;
            end
            e.cnt = model_cnt;
            e.gap = gap;
            e.b2b = !first;
            first = 1'b0;
            exp_q.push_back(e);
        end
        for (int i = 0; i < N; i++) begin
            foreach (stage[i][j]) wq[i].push_back(stage[i][j]);
            stage[i].delete();
        end
        if (toggle) begin
            k = 0;
            while (k < 200) begin
                @(negedge clk);
                if (tx_start) break;
                k++;
            end
            @(posedge clk);
            #1 cfg_req_mask = ~mask;
            @(posedge clk);
            #1 cfg_req_mask = mask;
        end
        k = 0;
        while ((exp_q.size() != 0 || mon_busy) && k < 20000) begin
            @(posedge clk);
            k++;
        end
        chk("episode_complete", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
        for (int i = 0; i < N; i++) if (!mask[i]) wq[i].delete();
        repeat (gap + 4) @(posedge clk);
        @(negedge clk);
        chk("busy_idle", 64'(busy), 64'(0));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
        chk({tag, "_req_done"}, 64'(req_done), 64'(0));
        chk({tag, "_req_err"}, 64'(req_err), 64'(0));
        chk({tag, "_tx_start"}, 64'(tx_start), 64'(0));
        chk({tag, "_tx_data"}, 64'(tx_data), 64'(0));
        chk({tag, "_tx_len"}, 64'(tx_len), 64'(0));
        chk({tag, "_tx_parity_en"}, 64'(tx_parity_en), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_cur_grant"}, 64'(cur_grant), 64'(0));
        chk({tag, "_word_cnt"}, 64'(word_cnt), 64'(0));
    endtask

    initial begin
        int k;
        rst_n        = 1'b0;
        cfg_rr_en    = 1'b0;
        cfg_req_mask = '0;
        cfg_gap      = '0;
        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // Single word from requester 0.
        push_word(0, 32'hA5A5_0F0F, 6'd32, 1'b0);
        run_episode(1'b1, 4'b1111, 0, 0, 1'b0);
        chk("first_word_cnt", 64'(word_cnt), 64'(1));

        // Round-robin and fixed priority with all requesters pending.
        for (int i = 0; i < N; i++) gen_words(i, 2, 0);
        run_episode(1'b1, 4'b1111, 3, 0, 1'b0);
        gen_words(0, 3, 0);
        for (int i = 1; i < N; i++) gen_words(i, 1, 0);
        run_episode(1'b0, 4'b1111, 3, 0, 1'b0);

        // Masked requester 1, with the mask disturbed mid-word.
        for (int i = 0; i < N; i++) gen_words(i, 2, 0);
        run_episode(1'b1, 4'b1101, 2, 0, 1'b1);

        // Illegal lengths, then timeout, then simultaneous done+err.
        push_word(2, 32'h1111_2222, 6'd7, 1'b1);
        push_word(2, 32'h3333_4444, 6'd33, 1'b0);
        push_word(3, 32'h5555_6666, 6'd8, 1'b1);
        run_episode(1'b1, 4'b1111, 1, 0, 1'b0);
        push_word(1, 32'hDEAD_BEEF, 6'd16, 1'b1);
        run_episode(1'b1, 4'b1111, 2, 3, 1'b0);
        push_word(0, 32'hCAFE_F00D, 6'd24, 1'b0);
        run_episode(1'b1, 4'b1111, 0, 2, 1'b0);

        // Reset while waiting for the engine.
        mon_en = 1'b0;
        cfg_rr_en    = 1'b1;
        cfg_req_mask = 4'b1111;
        eng_q.push_back('{kind: 3, dly: 1, echo: 1'b0, echo_err: 1'b0});
        push_word(2, 32'h0BAD_F00D, 6'd20, 1'b1);
        wq[2].push_back(stage[2].pop_front());
        k = 0;
        while (k < 100) begin
            @(negedge clk);
            if (tx_start) break;
            k++;
        end
        chk("reset_test_started", 64'(tx_start), 64'(1));
        repeat (2) @(posedge clk);
        #1 chk("busy_before_reset", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1 chk_zero("midword_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_ptr = 0;
        model_cnt = '0;
        @(negedge clk);
        chk("post_reset_cur_grant", 64'(cur_grant), 64'(0));
        chk("post_reset_busy", 64'(busy), 64'(0));
        mon_en = 1'b1;
        for (int i = 0; i < N; i++) gen_words(i, 1, 0);
        run_episode(1'b1, 4'b1111, 1, 0, 1'b0);

        // Randomized episodes.
        for (int ep = 0; ep < 30; ep++) begin
            for (int i = 0; i < N; i++) gen_words(i, int'($urandom_range(0, 3)), 20);
            run_episode(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
                        int'($urandom_range(0, 5)), -1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
